// File: rtl/execute_branch_resolve.sv
// execute_branch_resolve: resolves branch conditions against flags, raises redirects on mispredict, and counts branches.
module execute_branch_resolve #(
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              iCLOCK,
    input  logic              iRESET_SYNC,
    input  logic              iCTRL_HOLD,
    input  logic [4:0]        iFLAG,
    input  logic              iPREV_INST_VALID,
    input  logic              iPREV_BRANCH,
    input  logic [3:0]        iPREV_CC,
    input  logic [ADDR_W-1:0] iPREV_PC,
    input  logic [ADDR_W-1:0] iPREV_JUMP_ADDR,
    input  logic              iPREV_PRED_TAKEN,
    input  logic [ADDR_W-1:0] iPREV_PRED_ADDR,
    output logic              oPREV_BUSY,
    output logic              oJUMP_VALID,
    output logic [ADDR_W-1:0] oJUMP_ADDR,
    input  logic              iJUMP_ACK,
    output logic              oFLUSH,
    output logic [CNT_W-1:0]  oBRANCH_COUNT,
    output logic [CNT_W-1:0]  oMISS_COUNT
);
    typedef enum logic {IDLE, REQ} state_t;
    state_t              r_state;
    logic                r_jump_valid, r_flush;
    logic [ADDR_W-1:0]   r_jump_addr;
    logic [CNT_W-1:0]    r_branch_cnt, r_miss_cnt;
    logic                w_zf, w_pf, w_cf, w_of, w_sf, w_lt;
    logic                w_taken, w_accept, w_miss;
    logic [ADDR_W-1:0]   w_target;
    assign {w_sf, w_of, w_cf, w_pf, w_zf} = iFLAG;
    assign w_lt = w_sf ^ w_of;
    always_comb begin
        w_taken = 1'b0;
        case (iPREV_CC)
            4'd0:  w_taken = 1'b1;
            4'd1:  w_taken = w_zf;
            4'd2:  w_taken = ~w_zf;
            4'd3:  w_taken = w_sf;
            4'd4:  w_taken = ~w_sf;
            4'd5:  w_taken = w_cf;
            4'd6:  w_taken = ~w_cf;
            4'd7:  w_taken = w_of;
            4'd8:  w_taken = ~w_of;
            4'd9:  w_taken = ~w_zf & ~w_lt;
            4'd10: w_taken = ~w_lt;
            4'd11: w_taken = w_lt;
            4'd12: w_taken = w_zf | w_lt;
            4'd13: w_taken = w_pf;
            4'd14: w_taken = ~w_pf;
            default: w_taken = 1'b0;
        endcase
    end
    assign w_accept = iPREV_INST_VALID & ~iCTRL_HOLD & (r_state == IDLE) & iPREV_BRANCH;
    assign w_target = w_taken ? iPREV_JUMP_ADDR : iPREV_PC + ADDR_W'(4);
    assign w_miss   = (w_taken != iPREV_PRED_TAKEN) |
                      (w_taken & iPREV_PRED_TAKEN & (iPREV_PRED_ADDR != iPREV_JUMP_ADDR));
    always_ff @(posedge iCLOCK) begin
        if (iRESET_SYNC) begin
            r_state      <= IDLE;
            r_jump_valid <= 1'b0;
            r_jump_addr  <= '0;
            r_flush      <= 1'b0;
            r_branch_cnt <= '0;
            r_miss_cnt   <= '0;
        end else begin
            r_flush <= 1'b0;
            if (w_accept) begin
                r_branch_cnt <= r_branch_cnt + CNT_W'(~&r_branch_cnt);
                if (w_miss) begin
                    r_miss_cnt   <= r_miss_cnt + CNT_W'(~&r_miss_cnt);
                    r_state      <= REQ;
                    r_jump_valid <= 1'b1;
                    r_jump_addr  <= w_target;
                    r_flush      <= 1'b1;
                end
            end
            if (r_state == REQ && iJUMP_ACK) begin
                r_state      <= IDLE;
                r_jump_valid <= 1'b0;
            end
        end
    end
    assign oPREV_BUSY    = (r_state == REQ);
    assign oJUMP_VALID   = r_jump_valid;
    assign oJUMP_ADDR    = r_jump_addr;
    assign oFLUSH        = r_flush;
    assign oBRANCH_COUNT = r_branch_cnt;
    assign oMISS_COUNT   = r_miss_cnt;
endmodule

// File: doc/execute_branch_resolve.md
Name: execute_branch_resolve

Overview:
- Execute-stage consumer of the 5-bit flag register output. It evaluates a branch instruction's condition code against the current flags and compares the outcome with the fetch-stage prediction.
- On a mispredict it raises a redirect request to fetch with a valid/ack handshake and stalls the upstream stage until the request is accepted.
- It keeps saturating branch and mispredict counters for performance monitoring.

Parameters:
- ADDR_W, 32, width of PC and target addresses.
- CNT_W, 16, width of the statistics counters.

Ports:
- iCLOCK  in  1  single clock, all state updates on rising edge.
- iRESET_SYNC  in  1  synchronous reset, active-high.
- iCTRL_HOLD  in  1  global pipeline hold; blocks instruction acceptance.
- iFLAG  in  5  current flags: [0] ZF, [1] PF, [2] CF, [3] OF, [4] SF.
- iPREV_INST_VALID  in  1  upstream instruction valid.
- iPREV_BRANCH  in  1  instruction is a conditional or unconditional branch.
- iPREV_CC  in  4  condition code.
- iPREV_PC  in  ADDR_W  branch instruction address.
- iPREV_JUMP_ADDR  in  ADDR_W  resolved branch target.
- iPREV_PRED_TAKEN  in  1  fetch prediction (taken or not).
- iPREV_PRED_ADDR  in  ADDR_W  fetch predicted target.
- oPREV_BUSY  out  1  stall to upstream.
- oJUMP_VALID  out  1  redirect request to fetch.
- oJUMP_ADDR  out  ADDR_W  redirect address.
- iJUMP_ACK  in  1  fetch accepts the redirect.
- oFLUSH  out  1  one-cycle pulse; kills younger in-flight instructions.
- oBRANCH_COUNT  out  CNT_W  resolved branches, saturating.
- oMISS_COUNT  out  CNT_W  mispredicts, saturating.

Behaviour:
- Reset (iRESET_SYNC=1 at an edge):
  - state=IDLE.
  - oJUMP_VALID=0, oJUMP_ADDR=0, oFLUSH=0, both counters=0.
  - Reset overrides everything, including a pending request mid-handshake, which is dropped.
- oPREV_BUSY is combinational: 1 when state==REQ, else 0.
- Accept condition: iPREV_INST_VALID & ~iCTRL_HOLD & (state==IDLE).
  - Non-branch instructions are accepted with no effect.
- Condition evaluation (combinational, uses iFLAG in the accept cycle):
  - 0 always; 1 ZF; 2 ~ZF; 3 SF; 4 ~SF; 5 CF; 6 ~CF; 7 OF; 8 ~OF.
  - 9 ~ZF&(SF==OF); 10 SF==OF; 11 SF!=OF; 12 ZF|(SF!=OF).
  - 13 PF; 14 ~PF; 15 never.
- Resolution for an accepted branch:
  - target = taken ? iPREV_JUMP_ADDR : iPREV_PC+4, truncated to ADDR_W (wraps at all-ones).
  - mispredict = (taken != iPREV_PRED_TAKEN) | (taken & iPREV_PRED_TAKEN & (iPREV_PRED_ADDR != iPREV_JUMP_ADDR)).
- State machine IDLE/REQ:
  - IDLE to REQ: at the edge after accepting a mispredicted branch. Registered effects: oJUMP_VALID=1, oJUMP_ADDR=target, oFLUSH=1 for exactly that one cycle. Latency from accept to request is 1 cycle.
  - REQ: oJUMP_VALID and oJUMP_ADDR stay stable until acked. No new instruction is accepted.
  - REQ to IDLE: at the edge where iJUMP_ACK=1. oJUMP_VALID=0 from the next cycle. Accepting can resume that same next cycle.
  - If iJUMP_ACK is already 1 in the first REQ cycle, REQ lasts exactly one cycle.
  - iCTRL_HOLD does not freeze REQ; an ack during hold still completes the handshake.
  - iJUMP_ACK in IDLE is ignored.
- Counters:
  - oBRANCH_COUNT increments on every accepted branch.
  - oMISS_COUNT increments on every accepted mispredicted branch.
  - Both saturate at all-ones and never wrap.
- Correctly predicted branches produce no request, no flush and no stall.

Test Plan:
- Reset sequence: assert iRESET_SYNC 2 cycles with random inputs -> oJUMP_VALID=0, oFLUSH=0, oPREV_BUSY=0, counters=0.
- Correct prediction: iFLAG=5'b00001, CC=1, PRED_TAKEN=1, PRED_ADDR=JUMP_ADDR=0x100 -> no oJUMP_VALID; BRANCH_COUNT=1, MISS_COUNT=0.
- Mispredict taken, ack 3 cycles late:
  - Stimulus: iFLAG=0, CC=2, PRED_TAKEN=0, JUMP_ADDR=0x2000.
  - Next cycle: oJUMP_VALID=1, oJUMP_ADDR=0x2000, oFLUSH=1 for one cycle.
  - oPREV_BUSY=1 until ack; oJUMP_VALID drops the cycle after ack; MISS_COUNT=1.
- Mispredict not-taken with PC wrap: CC=15, PRED_TAKEN=1, PC=0xFFFFFFFC -> oJUMP_ADDR=0x00000000.
- Hold and reset interaction:
  - iCTRL_HOLD=1 with a valid mispredicting branch -> no accept, no count change.
  - Reset asserted during REQ -> oJUMP_VALID=0 the next cycle and the request is never re-raised.
- Saturation: CNT_W=2, 5 mispredicts, each acked -> both counters=3.
